// File: rtl/fm_pkg.sv
// Shared constants for the FM-index C-table builder: alphabet, symbol codes and FSM encoding.
package fm_pkg;

    localparam int SYM_W = 2;
    localparam int ALPHA = 4;

    localparam logic [1:0] SYM_A = 2'b00;
    localparam logic [1:0] SYM_C = 2'b01;
    localparam logic [1:0] SYM_G = 2'b10;
    localparam logic [1:0] SYM_T = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_COUNT  = 2'b01,
        ST_PREFIX = 2'b10,
        ST_READY  = 2'b11
    } state_t;

endpackage

// File: rtl/c_table_builder_if.sv
// Control, status and lookup bundle of the C-table builder; master drives it, the builder is the slave.
interface c_table_builder_if #(
    parameter int DATA_W    = 8,
    parameter int NUM_PORTS = 2
);
    import fm_pkg::*;

    logic                        start;
    logic                        sym_valid;
    logic [SYM_W-1:0]            sym_in;
    logic                        sym_last;
    logic                        busy;
    logic                        ready;
    logic                        sat_err;
    logic [NUM_PORTS-1:0]        ce;
    logic [SYM_W*NUM_PORTS-1:0]  symbol;
    logic [DATA_W*NUM_PORTS-1:0] data;

    modport master (
        output start, sym_valid, sym_in, sym_last, ce, symbol,
        input  busy, ready, sat_err, data
    );

    modport slave (
        input  start, sym_valid, sym_in, sym_last, ce, symbol,
        output busy, ready, sat_err, data
    );

endinterface

// File: rtl/c_table_builder_rdport.sv
// One registered lookup channel into the flattened C table; returns zero unless enabled and ready.
module c_table_rdport
    import fm_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    ready,
    input  logic [SYM_W-1:0]        symbol,
    input  logic [ALPHA*DATA_W-1:0] c_flat,
    output logic [DATA_W-1:0]       data
);

    logic [DATA_W-1:0] data_r;

    // Registered lookup, forced to zero when idle or the table is not valid
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= {DATA_W{1'b0}};
        end else if (ce && ready) begin
            data_r <= c_flat[32'(symbol) * DATA_W +: DATA_W];
        end else begin
            data_r <= {DATA_W{1'b0}};
        end
    end

    assign data = data_r;

endmodule

// File: rtl/c_table_builder.sv
// Self-building FM-index C table: counts streamed symbols, forms prefix sums in place, serves lookups.
module c_table_builder
    import fm_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_PORTS = 2
) (
    input  logic             clk,
    input  logic             rst,
    c_table_builder_if.slave bus
);

    state_t                      state_r, state_next_s;
    logic [DATA_W-1:0]           cnt_r [ALPHA];
    logic [DATA_W-1:0]           c_r   [ALPHA];
    logic [1:0]                  k_r;
    logic                        busy_r, ready_r, sat_err_r;
    logic                        busy_s, ready_s, clear_s;
    logic [DATA_W:0]             inc_s, sum_s;
    logic [ALPHA*DATA_W-1:0]     c_flat_s;
    logic [DATA_W*NUM_PORTS-1:0] data_s;

    // Saturating add; MSB of the result flags that the sum was clipped
    function automatic logic [DATA_W:0] sat_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [DATA_W:0] raw_v;
        raw_v = {1'b0, a} + {1'b0, b};
        if (raw_v[DATA_W]) begin
            return {1'b1, {DATA_W{1'b1}}};
        end else begin
            return raw_v;
        end
    endfunction

    // Start is honoured everywhere except mid-prefix, where the sums are in flight
    assign clear_s = bus.start && (state_r != ST_PREFIX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; start outranks a coincident last symbol
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:   state_next_s = bus.start ? ST_COUNT : ST_IDLE;
            ST_COUNT:  begin
                if (bus.start) begin
                    state_next_s = ST_COUNT;
                end else if (bus.sym_valid && bus.sym_last) begin
                    state_next_s = ST_PREFIX;
                end else begin
                    state_next_s = ST_COUNT;
                end
            end
            ST_PREFIX: state_next_s = (k_r == 2'd3) ? ST_READY : ST_PREFIX;
            ST_READY:  state_next_s = bus.start ? ST_COUNT : ST_READY;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Status decode from the upcoming state so the flags register alongside it
    always_comb begin
        busy_s  = 1'b0;
        ready_s = 1'b0;
        case (state_next_s)
            ST_COUNT, ST_PREFIX: busy_s  = 1'b1;
            ST_READY:            ready_s = 1'b1;
            default: begin
                busy_s  = 1'b0;
                ready_s = 1'b0;
            end
        endcase
    end

    // Saturating count increment and prefix-sum step
    always_comb begin
        inc_s = sat_add(cnt_r[bus.sym_in], {{(DATA_W-1){1'b0}}, 1'b1});
        sum_s = sat_add(c_r[k_r - 2'd1], cnt_r[k_r - 2'd1]);
    end

    // Counters, C table, prefix index and status flags
    always_ff @(posedge clk) begin
        if (rst || clear_s) begin
            for (int i = 0; i < ALPHA; i++) begin
                cnt_r[i] <= {DATA_W{1'b0}};
                c_r[i]   <= {DATA_W{1'b0}};
            end
            k_r       <= 2'd1;
            sat_err_r <= 1'b0;
            busy_r    <= rst ? 1'b0 : 1'b1;
            ready_r   <= 1'b0;
        end else begin
            busy_r  <= busy_s;
            ready_r <= ready_s;
            if (state_r == ST_COUNT && bus.sym_valid) begin
                cnt_r[bus.sym_in] <= inc_s[DATA_W-1:0];
                if (inc_s[DATA_W]) begin
                    sat_err_r <= 1'b1;
                end else begin
                    sat_err_r <= sat_err_r;
                end
            end else if (state_r == ST_PREFIX) begin
                c_r[k_r] <= sum_s[DATA_W-1:0];
                k_r      <= k_r + 2'd1;
                if (sum_s[DATA_W]) begin
                    sat_err_r <= 1'b1;
                end else begin
                    sat_err_r <= sat_err_r;
                end
            end else begin
                k_r <= k_r;
            end
        end
    end

    // Flatten the table for the read ports
    always_comb begin
        c_flat_s = {ALPHA*DATA_W{1'b0}};
        for (int i = 0; i < ALPHA; i++) begin
            c_flat_s[i*DATA_W +: DATA_W] = c_r[i];
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        c_table_rdport #(.DATA_W(DATA_W)) u_rdport (
            .clk    (clk),
            .rst    (rst),
            .ce     (bus.ce[p]),
            .ready  (ready_r),
            .symbol (bus.symbol[SYM_W*p +: SYM_W]),
            .c_flat (c_flat_s),
            .data   (data_s[DATA_W*p +: DATA_W])
        );
    end

    assign bus.busy    = busy_r;
    assign bus.ready   = ready_r;
    assign bus.sat_err = sat_err_r;
    assign bus.data    = data_s;

endmodule
